// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic array sequencer.
package tpu_pkg;

  localparam int unsigned DIM_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/systolic_seq_if.sv
// Control/status bundle between the pass requester and the systolic sequencer.
interface systolic_seq_if #(
  parameter int unsigned DIM   = 8,
  parameter int unsigned CNT_W = $clog2(3 * DIM)
);

  logic             start;
  logic             clr_acc;
  logic             stall;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             done;
  logic             mac_en;
  logic             mac_wren;
  logic             cin_zero;
  logic [CNT_W-1:0] skew_t;
  logic [DIM-1:0]   lane_vld;

  modport master (
    output start, clr_acc, stall, abort,
    input  ready, busy, done, mac_en, mac_wren, cin_zero, skew_t, lane_vld
  );

  modport slave (
    input  start, clr_acc, stall, abort,
    output ready, busy, done, mac_en, mac_wren, cin_zero, skew_t, lane_vld
  );

endinterface

// File: rtl/skew_lane_mask.sv
// Flags which rows/columns receive a real operand at skew cycle skew_t.
module skew_lane_mask #(
  parameter int unsigned DIM   = 8,
  parameter int unsigned CNT_W = $clog2(3 * DIM)
) (
  input  logic             run,
  input  logic [CNT_W-1:0] skew_t,
  output logic [DIM-1:0]   lane_vld
);

  // Lane i carries operand index skew_t - i, valid while that index is in 0..DIM-1.
  always_comb begin
    lane_vld = '0;
    for (int i = 0; i < DIM; i++) begin
      if (run && (skew_t >= CNT_W'(i)) && ((skew_t - CNT_W'(i)) < CNT_W'(DIM))) begin
        lane_vld[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_seq.sv
// Sequencer for one DIM x DIM systolic matrix-multiply pass: clear, skewed run, done.
module systolic_seq
  import tpu_pkg::*;
#(
  parameter int unsigned DIM   = DIM_DEFAULT,
  parameter int unsigned CNT_W = $clog2(3 * DIM)
) (
  input logic          clk,
  input logic          rst_n,
  systolic_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_T = CNT_W'(3 * DIM - 3);

  seq_state_t       state;
  logic [CNT_W-1:0] skew_t;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      skew_t <= '0;
    end else begin
      case (state)
        IDLE: begin
          skew_t <= '0;
          if (bus.start) state <= bus.clr_acc ? CLEAR : RUN;
        end
        CLEAR: begin
          skew_t <= '0;
          state  <= bus.abort ? IDLE : RUN;
        end
        RUN: begin
          // Abort wins over both stall and the final-cycle transition.
          if (bus.abort) begin
            state  <= IDLE;
            skew_t <= '0;
          end else if (!bus.stall) begin
            if (skew_t == LAST_T) begin
              state  <= DONE;
              skew_t <= '0;
            end else begin
              skew_t <= skew_t + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          skew_t <= '0;
        end
        default: begin
          state  <= IDLE;
          skew_t <= '0;
        end
      endcase
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.mac_en   = (state == RUN) && !bus.stall;
  assign bus.mac_wren = (state == CLEAR);
  assign bus.cin_zero = (state == CLEAR);
  assign bus.skew_t   = skew_t;

  skew_lane_mask #(
    .DIM   (DIM),
    .CNT_W (CNT_W)
  ) u_lane_mask (
    .run      (state == RUN),
    .skew_t   (skew_t),
    .lane_vld (bus.lane_vld)
  );

endmodule
